uart_rx_frame: RTL and testbench

- 8N1 UART receiver that samples the serial line driven by the UART transmitter stage (RX232 line) and recovers parallel bytes.
- Sits directly downstream of the transmit path: on-board loopback and the host-link receive side.
- Emits one byte per valid frame with a single-cycle done strobe. Flags framing errors and rejects glitch starts.

---
 rtl/uart_rx_frame_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx_frame.sv | 130 +++++++++++++
 tb/tb_uart_rx_frame.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receive definitions: state encoding and bit-period helper.
// The helper is also used by the transmit side so both agree on timing.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus a third flop for falling-edge detection.
// Flops reset high so an idle-high line never looks like an edge.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 3-sample majority vote, glitch-start rejection
// and framing-error detection with break hold-off.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx232,
  output logic [7:0] data_rx,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CYC  = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);
  localparam logic [CW-1:0] HALF_V = CW'(HALF_CYC);
  localparam logic [CW-1:0] LAST_V = CW'(BIT_CYC - 1);

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  hist_q;
  logic        s2, fall, vote;

  uart_rx_sync u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(rx232),
    .sync_o (s2),
    .fall_o (fall)
  );

  // Vote over the current sample and the two before it.
  assign vote = (hist_q[1] & hist_q[0]) |
                (hist_q[1] & s2) |
                (hist_q[0] & s2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      hist_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      hist_q  <= {hist_q[0], s2};
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          cyc_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cyc_q == HALF_V) begin
          cyc_d   = '0;
          idx_d   = '0;
          state_d = vote ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_q == LAST_V) begin
          cyc_d = '0;
          sh_d  = {vote, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_q == LAST_V) begin
          cyc_d = '0;
          if (vote) begin
            data_d  = sh_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      BREAK: begin
        if (s2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_rx   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame at 1 Mbaud / 50 MHz.
// Each scenario task drives the line and checks its own results.
module tb_uart_rx_frame;

  localparam int BC = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx232 = 1'b1;
  logic [7:0] data_rx;
  logic       rx_done, frame_err, rx_busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_busy = 0;
  int t_last = 0;
  int t_prev = 0;
  logic [7:0] d_last = 8'h00;
  logic [7:0] d_prev = 8'h00;
  bit both = 1'b0;

  uart_rx_frame #(
    .CLK_FREQ (50_000_000),
    .BAUD_RATE(1_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx232    (rx232),
    .data_rx  (data_rx),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      n_done <= n_done + 1;
      t_prev <= t_last;
      t_last <= cyc;
      d_prev <= d_last;
      d_last <= data_rx;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_busy) n_busy <= n_busy + 1;
    if (rx_done && frame_err) both <= 1'b1;
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // spike_bit: data bit index to get a 1-cycle inversion at mid-bit, -1 none
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int spike_bit);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BC; c++) begin
        if (k == spike_bit + 1 && c == 25) rx232 = ~fr[k];
        else rx232 = fr[k];
        @(negedge clk);
      end
    end
    rx232 = 1'b1;
  endtask

  task automatic test_reset();
    rx232 = 1'b1;
    rst = 1'b1;
    wait_cyc(4);
    n_chk++;
    if (data_rx !== 8'h00) $display("FAIL reset_data got %h want 00", data_rx);
    else n_pass++;
    n_chk++;
    if (rx_done !== 1'b0) $display("FAIL reset_done got %b want 0", rx_done);
    else n_pass++;
    n_chk++;
    if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err);
    else n_pass++;
    n_chk++;
    if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rx_busy);
    else n_pass++;
    rst = 1'b0;
    wait_cyc(5);
  endtask

  task automatic test_frame_49();
    int d0, f0, t0;
    d0 = n_done;
    f0 = n_ferr;
    t0 = cyc;
    send_frame(8'h49, 1'b1, -1);
    wait_cyc(5);
    n_chk++;
    if (n_done - d0 !== 1) $display("FAIL f49_count got %0d want 1", n_done - d0);
    else n_pass++;
    n_chk++;
    if (data_rx !== 8'h49) $display("FAIL f49_data got %h want 49", data_rx);
    else n_pass++;
    n_chk++;
    if (n_ferr - f0 !== 0) $display("FAIL f49_ferr got %0d want 0", n_ferr - f0);
    else n_pass++;
    n_chk++;
    if (t_last - t0 < 470 || t_last - t0 > 490)
      $display("FAIL f49_latency got %0d want 470..490", t_last - t0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = n_done;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_cyc(5);
    n_chk++;
    if (n_done - d0 !== 2) $display("FAIL b2b_count got %0d want 2", n_done - d0);
    else n_pass++;
    n_chk++;
    if (d_prev !== 8'h00) $display("FAIL b2b_first got %h want 00", d_prev);
    else n_pass++;
    n_chk++;
    if (d_last !== 8'hFF) $display("FAIL b2b_second got %h want ff", d_last);
    else n_pass++;
    n_chk++;
    if (t_last - t_prev !== 500)
      $display("FAIL b2b_spacing got %0d want 500", t_last - t_prev);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int d0, f0, b0;
    d0 = n_done;
    f0 = n_ferr;
    b0 = n_busy;
    rx232 = 1'b0;
    wait_cyc(10);
    rx232 = 1'b1;
    wait_cyc(100);
    n_chk++;
    if (n_done - d0 !== 0) $display("FAIL glitch_done got %0d want 0", n_done - d0);
    else n_pass++;
    n_chk++;
    if (n_ferr - f0 !== 0) $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0);
    else n_pass++;
    n_chk++;
    if (n_busy - b0 < 24 || n_busy - b0 > 28)
      $display("FAIL glitch_busy got %0d want 24..28", n_busy - b0);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    int d0, f0;
    d0 = n_done;
    f0 = n_ferr;
    send_frame(8'hA5, 1'b0, -1);
    rx232 = 1'b0;
    wait_cyc(3 * BC);
    n_chk++;
    if (n_ferr - f0 !== 1) $display("FAIL ferr_count got %0d want 1", n_ferr - f0);
    else n_pass++;
    n_chk++;
    if (n_done - d0 !== 0) $display("FAIL ferr_done got %0d want 0", n_done - d0);
    else n_pass++;
    n_chk++;
    if (data_rx !== 8'hFF) $display("FAIL ferr_data_held got %h want ff", data_rx);
    else n_pass++;
    n_chk++;
    if (rx_busy !== 1'b1) $display("FAIL ferr_busy_low got %b want 1", rx_busy);
    else n_pass++;
    rx232 = 1'b1;
    wait_cyc(10);
    n_chk++;
    if (rx_busy !== 1'b0) $display("FAIL ferr_busy_idle got %b want 0", rx_busy);
    else n_pass++;
    d0 = n_done;
    send_frame(8'h3C, 1'b1, -1);
    wait_cyc(5);
    n_chk++;
    if (n_done - d0 !== 1) $display("FAIL ferr_next_count got %0d want 1", n_done - d0);
    else n_pass++;
    n_chk++;
    if (data_rx !== 8'h3C) $display("FAIL ferr_next_data got %h want 3c", data_rx);
    else n_pass++;
  endtask

  task automatic test_spike();
    int d0;
    d0 = n_done;
    send_frame(8'h49, 1'b1, 2);
    wait_cyc(5);
    n_chk++;
    if (n_done - d0 !== 1) $display("FAIL spike_count got %0d want 1", n_done - d0);
    else n_pass++;
    n_chk++;
    if (data_rx !== 8'h49) $display("FAIL spike_data got %h want 49", data_rx);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int d0, f0;
    logic [9:0] fr;
    d0 = n_done;
    f0 = n_ferr;
    fr = {1'b1, 8'h49, 1'b0};
    for (int k = 0; k < 5; k++) begin
      rx232 = fr[k];
      wait_cyc(BC);
    end
    rx232 = fr[5];
    wait_cyc(25);
    rst = 1'b1;
    rx232 = 1'b1;
    #1;
    n_chk++;
    if (data_rx !== 8'h00) $display("FAIL mrst_data got %h want 00", data_rx);
    else n_pass++;
    n_chk++;
    if (rx_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", rx_busy);
    else n_pass++;
    n_chk++;
    if (rx_done !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL mrst_pulses got %b%b want 00", rx_done, frame_err);
    else n_pass++;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(600);
    n_chk++;
    if (n_done - d0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL mrst_partial got %0d/%0d want 0/0", n_done - d0, n_ferr - f0);
    else n_pass++;
    send_frame(8'h5A, 1'b1, -1);
    wait_cyc(5);
    n_chk++;
    if (n_done - d0 !== 1) $display("FAIL mrst_next_count got %0d want 1", n_done - d0);
    else n_pass++;
    n_chk++;
    if (data_rx !== 8'h5A) $display("FAIL mrst_next_data got %h want 5a", data_rx);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_49();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_spike();
    test_mid_reset();
    n_chk++;
    if (both !== 1'b0) $display("FAIL done_and_ferr got %b want 0", both);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
